byte_frame_checker: RTL and testbench

//  Downstream consumer of the 8-bit registered byte stream written into the circular store.

---
 rtl/byte_frame_pkg.sv | 25 ++
 rtl/frame_timeout_ctr.sv | 29 ++
 rtl/byte_frame_checker.sv | 180 ++++++++++++++++++
 tb/tb_byte_frame_checker.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/byte_frame_pkg.sv
// Shared types for the byte frame checker: FSM states, error causes,
// the default sync marker and a saturating counter helper.
package byte_frame_pkg;

   typedef enum logic [1:0] {
      HUNT,
      LEN,
      PAY,
      CSUM
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_LEN,
      ERR_CSUM,
      ERR_TMO
   } err_t;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

endpackage

// File: rtl/frame_timeout_ctr.sv
// Idle-cycle counter; expire fires on the TIMEOUT-th consecutive
// enabled cycle without clr, then the counter restarts from zero.
module frame_timeout_ctr #(
   parameter int unsigned TIMEOUT = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int W = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0] LIM = W'(TIMEOUT - 1);

   logic [W-1:0] cnt;

   assign expire = en & ~clr & (cnt == LIM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr | ~en | expire)
         cnt <= '0;
      else
         cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/byte_frame_checker.sv
// Sync-hunting, length-prefixed frame parser with 8-bit checksum check.
// Define BYTE_FRAME_STATS_EN to add saturating per-cause error counters.
module byte_frame_checker
   import byte_frame_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE = SYNC_DEFAULT,
   parameter int unsigned MAX_LEN   = 16,
   parameter int unsigned TIMEOUT   = 32,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             pay_valid,
   output logic [7:0]       pay_data,
   output logic             pay_last,
   output logic             frame_ok,
   output logic             frame_err,
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt
`ifdef BYTE_FRAME_STATS_EN
   ,
   output logic [7:0]       len_err_cnt,
   output logic [7:0]       csum_err_cnt,
   output logic [7:0]       tmo_err_cnt
`endif
);

   localparam logic [7:0] MAX_B = 8'(MAX_LEN);

   state_t     state, state_nx;
   logic [7:0] acc;
   logic [7:0] len_cnt;
   logic [7:0] sum;
   logic       tmo;
   logic       pay_v_d;
   logic       pay_l_d;
   logic       ok_d;
   err_t       err_d;

   assign busy = (state != HUNT);
   assign sum  = acc + in_data;

   frame_timeout_ctr #(
      .TIMEOUT(TIMEOUT)
   ) u_tmo (
      .clk   (clk),
      .rst   (rst),
      .clr   (in_valid),
      .en    (busy),
      .expire(tmo)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= HUNT;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         HUNT:
            if (in_valid && in_data == SYNC_BYTE)
               state_nx = LEN;
         LEN:
            if (tmo)
               state_nx = HUNT;
            else if (in_valid) begin
               if (in_data > MAX_B)
                  state_nx = HUNT;
               else if (in_data == 8'd0)
                  state_nx = CSUM;
               else
                  state_nx = PAY;
            end
         PAY:
            if (tmo)
               state_nx = HUNT;
            else if (in_valid && len_cnt == 8'd1)
               state_nx = CSUM;
         CSUM:
            if (tmo || in_valid)
               state_nx = HUNT;
         default:
            state_nx = HUNT;
      endcase
   end

   always_comb begin
      pay_v_d = 1'b0;
      pay_l_d = 1'b0;
      ok_d    = 1'b0;
      err_d   = ERR_NONE;
      unique case (state)
         LEN:
            if (tmo)
               err_d = ERR_TMO;
            else if (in_valid && in_data > MAX_B)
               err_d = ERR_LEN;
         PAY:
            if (tmo)
               err_d = ERR_TMO;
            else if (in_valid) begin
               pay_v_d = 1'b1;
               pay_l_d = (len_cnt == 8'd1);
            end
         CSUM:
            if (tmo)
               err_d = ERR_TMO;
            else if (in_valid) begin
               if (sum == 8'd0)
                  ok_d = 1'b1;
               else
                  err_d = ERR_CSUM;
            end
         default: ;
      endcase
   end

   // acc starts at LEN so the closing byte only has to bring it to zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= 8'd0;
         len_cnt <= 8'd0;
      end else if (in_valid) begin
         unique case (state)
            LEN: begin
               acc     <= in_data;
               len_cnt <= in_data;
            end
            PAY: begin
               acc     <= sum;
               len_cnt <= len_cnt - 8'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pay_valid <= 1'b0;
         pay_data  <= 8'd0;
         pay_last  <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         frame_cnt <= '0;
      end else begin
         pay_valid <= pay_v_d;
         pay_last  <= pay_l_d;
         frame_ok  <= ok_d;
         frame_err <= (err_d != ERR_NONE);
         if (pay_v_d)
            pay_data <= in_data;
         if (ok_d)
            frame_cnt <= frame_cnt + CNT_W'(1);
      end
   end

`ifdef BYTE_FRAME_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_err_cnt  <= 8'd0;
         csum_err_cnt <= 8'd0;
         tmo_err_cnt  <= 8'd0;
      end else begin
         if (err_d == ERR_LEN)
            len_err_cnt <= sat_inc(len_err_cnt);
         if (err_d == ERR_CSUM)
            csum_err_cnt <= sat_inc(csum_err_cnt);
         if (err_d == ERR_TMO)
            tmo_err_cnt <= sat_inc(tmo_err_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_byte_frame_checker.sv
// Directed bench for byte_frame_checker with an event scoreboard;
// honours BYTE_FRAME_STATS_EN for the optional error counters.
module tb_byte_frame_checker;

   localparam int TMO = 32;
   localparam logic [1:0] EV_PAY = 2'd1;
   localparam logic [1:0] EV_OK  = 2'd2;
   localparam logic [1:0] EV_ERR = 2'd3;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] data;
      logic       last;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        pay_valid;
   logic [7:0]  pay_data;
   logic        pay_last;
   logic        frame_ok;
   logic        frame_err;
   logic        busy;
   logic [15:0] frame_cnt;
`ifdef BYTE_FRAME_STATS_EN
   logic [7:0]  len_err_cnt;
   logic [7:0]  csum_err_cnt;
   logic [7:0]  tmo_err_cnt;
`endif

   int  errors = 0;
   int  checks = 0;
   ev_t q[$];

   always #5 clk = ~clk;

   byte_frame_checker #(
      .SYNC_BYTE(8'hA5),
      .MAX_LEN  (16),
      .TIMEOUT  (TMO),
      .CNT_W    (16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .pay_valid(pay_valid),
      .pay_data (pay_data),
      .pay_last (pay_last),
      .frame_ok (frame_ok),
      .frame_err(frame_err),
      .busy     (busy),
      .frame_cnt(frame_cnt)
`ifdef BYTE_FRAME_STATS_EN
      ,
      .len_err_cnt (len_err_cnt),
      .csum_err_cnt(csum_err_cnt),
      .tmo_err_cnt (tmo_err_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pop_chk(input string tag, input ev_t got);
      ev_t e;
      checks++;
      assert (q.size() != 0) else begin
         errors++;
         $error("FAIL %s: got unexpected event %0h expected none", tag, got);
      end
      if (q.size() != 0) begin
         e = q.pop_front();
         chk(tag, 32'(got), 32'(e));
      end
   endtask

   task automatic mon();
      chk("excl", 32'(frame_ok & frame_err), 32'd0);
      if (pay_valid) pop_chk("pay", '{EV_PAY, pay_data, pay_last});
      if (frame_ok)  pop_chk("ok",  '{EV_OK, 8'd0, 1'b0});
      if (frame_err) pop_chk("err", '{EV_ERR, 8'd0, 1'b0});
   endtask

   task automatic step(input logic v, input logic [7:0] d);
      in_valid = v;
      in_data  = d;
      @(posedge clk);
      #1;
      mon();
   endtask

   task automatic send(input logic [7:0] d);
      step(1'b1, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00);
   endtask

   task automatic sp(input logic [7:0] d, input logic last);
      q.push_back('{EV_PAY, d, last});
      send(d);
   endtask

   task automatic fin_ok(input logic [7:0] d);
      q.push_back('{EV_OK, 8'd0, 1'b0});
      send(d);
   endtask

   task automatic fin_err(input logic [7:0] d);
      q.push_back('{EV_ERR, 8'd0, 1'b0});
      send(d);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_pv"}, 32'(pay_valid), 32'd0);
      chk({tag, "_pl"}, 32'(pay_last), 32'd0);
      chk({tag, "_pd"}, 32'(pay_data), 32'd0);
      chk({tag, "_ok"}, 32'(frame_ok), 32'd0);
      chk({tag, "_er"}, 32'(frame_err), 32'd0);
      chk({tag, "_bz"}, 32'(busy), 32'd0);
      chk({tag, "_cnt"}, 32'(frame_cnt), 32'd0);
`ifdef BYTE_FRAME_STATS_EN
      chk({tag, "_lec"}, 32'(len_err_cnt), 32'd0);
      chk({tag, "_cec"}, 32'(csum_err_cnt), 32'd0);
      chk({tag, "_tec"}, 32'(tmo_err_cnt), 32'd0);
`endif
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("rst");
      rst = 1'b0;

      // good frame with stalls just under the timeout
      send(8'hA5);
      chk("busy_len", 32'(busy), 32'd1);
      send(8'h03);
      sp(8'h11, 1'b0);
      idle(TMO - 1);
      chk("busy_stall", 32'(busy), 32'd1);
      sp(8'h22, 1'b0);
      idle(TMO - 1);
      sp(8'h33, 1'b1);
      fin_ok(8'h97);
      chk("cnt_good", 32'(frame_cnt), 32'd1);
      chk("busy_done", 32'(busy), 32'd0);

      // bad checksum
      send(8'hA5); send(8'h03);
      sp(8'h11, 1'b0); sp(8'h22, 1'b0); sp(8'h33, 1'b1);
      fin_err(8'h98);
      chk("cnt_bad", 32'(frame_cnt), 32'd1);

      // zero length, then over-length
      send(8'hA5); send(8'h00);
      fin_ok(8'h00);
      chk("cnt_len0", 32'(frame_cnt), 32'd2);
      send(8'hA5);
      fin_err(8'h11);
      chk("busy_len_err", 32'(busy), 32'd0);

      // garbage, then sync inside payload
      send(8'h00); send(8'hFF); send(8'h12);
      chk("busy_garbage", 32'(busy), 32'd0);
      send(8'hA5); send(8'h02);
      sp(8'hA5, 1'b0); sp(8'h10, 1'b1);
      fin_ok(8'h49);
      chk("cnt_sync_data", 32'(frame_cnt), 32'd3);

      // back-to-back frames, the second at maximum length
      send(8'hA5); send(8'h01);
      sp(8'h55, 1'b1);
      fin_ok(8'hAA);
      send(8'hA5); send(8'h10);
      for (int i = 1; i <= 16; i++) sp(8'(i), i == 16);
      fin_ok(8'h68);
      chk("cnt_b2b", 32'(frame_cnt), 32'd5);

      // truncated frame times out
      send(8'hA5); send(8'h02);
      sp(8'h11, 1'b0);
      idle(TMO - 1);
      chk("busy_pre_tmo", 32'(busy), 32'd1);
      q.push_back('{EV_ERR, 8'd0, 1'b0});
      idle(1);
      chk("busy_tmo", 32'(busy), 32'd0);
      chk("cnt_tmo", 32'(frame_cnt), 32'd5);
`ifdef BYTE_FRAME_STATS_EN
      chk("len_err_cnt", 32'(len_err_cnt), 32'd1);
      chk("csum_err_cnt", 32'(csum_err_cnt), 32'd1);
      chk("tmo_err_cnt", 32'(tmo_err_cnt), 32'd1);
`endif

      // reset mid-payload
      send(8'hA5); send(8'h04);
      sp(8'h11, 1'b0); sp(8'h22, 1'b0);
      rst = 1'b1;
      #1;
      chk_zero("midrst");
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(8'hA5); send(8'h03);
      sp(8'h11, 1'b0); sp(8'h22, 1'b0); sp(8'h33, 1'b1);
      fin_ok(8'h97);
      chk("cnt_post_rst", 32'(frame_cnt), 32'd1);

      idle(4);
      chk("sb_empty", 32'(q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
